dm_responder: RTL and testbench

- Data-memory responder for the pipelined CPU's `m_data_*` interface. It is the memory end of the CPU's M-stage load/store port.
- Decodes byte-enabled stores into a word array and returns load data combinationally in the same cycle.
- Logs every committed store as a (PC, word address, merged word) record into a small trace FIFO, drained by the bench over a valid/ready handshake.

---
 rtl/dm_responder.sv | 155 +++++++++++++++
 tb/tb_dm_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// dm_responder: data-memory responder for the CPU M-stage load/store port.
// Byte-enabled stores merge into a word array; loads read combinationally.
// Every committed store is logged as a (PC, word address, merged word)
// record into a trace FIFO drained over a valid/ready handshake.
// Optional feature macro: DM_ADDR_CHECK_EN (range-checks addresses and adds
// the sticky addr_err output; without it addresses alias freely).
module dm_responder #(
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      m_data_addr,
    input  logic [31:0]      m_data_wdata,
    input  logic [3:0]       m_data_byteen,
    input  logic [31:0]      m_inst_addr,
    output logic [31:0]      m_data_rdata,
    output logic             trc_valid,
    input  logic             trc_ready,
    output logic [31:0]      trc_pc,
    output logic [31:0]      trc_addr,
    output logic [31:0]      trc_data,
    output logic [CNT_W-1:0] trc_count,
`ifdef DM_ADDR_CHECK_EN
    output logic             addr_err,
`endif
    output logic             trc_overflow
);

    localparam int WORDS = 1 << ADDR_W;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [31:0]       mem [WORDS];
    logic [ADDR_W-1:0] idx;
    logic [31:0]       cur_word;
    logic [31:0]       merged;
    logic              in_range;
    logic              store_req;
    logic              store;

    logic [31:0]       fifo_pc   [FIFO_DEPTH];
    logic [31:0]       fifo_addr [FIFO_DEPTH];
    logic [31:0]       fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              full;
    logic              push;
    logic              pop;
    logic              drop;

    // Byte-offset bits never take part in word selection.
    logic unused_addr_bits;
    assign unused_addr_bits = ^m_data_addr[1:0];

    assign idx       = m_data_addr[ADDR_W+1:2];
    assign cur_word  = mem[idx];
    assign store_req = |m_data_byteen;

`ifdef DM_ADDR_CHECK_EN
    assign in_range  = (m_data_addr[31:ADDR_W+2] == '0);
`else
    assign in_range  = 1'b1;
`endif

    assign store = store_req & in_range;

    // Read path: zero-latency lookup; same-cycle store is not bypassed.
    always_comb begin
        m_data_rdata = cur_word;
        if (!in_range) begin
            m_data_rdata = '0;
        end
    end

    // Lane-by-lane merge of store data over the current word.
    always_comb begin
        merged = cur_word;
        if (m_data_byteen[0]) merged[7:0]   = m_data_wdata[7:0];
        if (m_data_byteen[1]) merged[15:8]  = m_data_wdata[15:8];
        if (m_data_byteen[2]) merged[23:16] = m_data_wdata[23:16];
        if (m_data_byteen[3]) merged[31:24] = m_data_wdata[31:24];
    end

    // Word array: full clear on reset, merged write on a committed store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                mem[i[ADDR_W-1:0]] <= '0;
            end
        end else if (store) begin
            mem[idx] <= merged;
        end
    end

    // A full FIFO still accepts a push when the head leaves at the same edge.
    assign full = (count == CNT_W'(FIFO_DEPTH));
    assign pop  = trc_valid & trc_ready;
    assign push = store & (~full | pop);
    assign drop = store & full & ~pop;

    // Trace FIFO storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc[i[PTR_W-1:0]]   <= '0;
                fifo_addr[i[PTR_W-1:0]] <= '0;
                fifo_data[i[PTR_W-1:0]] <= '0;
            end
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]   <= m_inst_addr;
                fifo_addr[wr_ptr] <= {m_data_addr[31:2], 2'b00};
                fifo_data[wr_ptr] <= merged;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef DM_ADDR_CHECK_EN
    // Sticky flag for any store attempted outside the array.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_err <= 1'b0;
        end else if (store_req && !in_range) begin
            addr_err <= 1'b1;
        end
    end
`endif

    assign trc_valid    = (count != '0);
    assign trc_count    = count;
    assign trc_overflow = overflow;
    assign trc_pc       = fifo_pc[rd_ptr];
    assign trc_addr     = fifo_addr[rd_ptr];
    assign trc_data     = fifo_data[rd_ptr];

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed self-checking bench for dm_responder.
module tb_dm_responder;

    logic        clk;
    logic        reset;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic        trc_valid;
    logic        trc_ready;
    logic [31:0] trc_pc;
    logic [31:0] trc_addr;
    logic [31:0] trc_data;
    logic [3:0]  trc_count;
    logic        trc_overflow;
`ifdef DM_ADDR_CHECK_EN
    logic        addr_err;
`endif

    int n_cmp;
    int n_bad;

    dm_responder #(.ADDR_W(12), .FIFO_DEPTH(8), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .m_data_addr  (m_data_addr),
        .m_data_wdata (m_data_wdata),
        .m_data_byteen(m_data_byteen),
        .m_inst_addr  (m_inst_addr),
        .m_data_rdata (m_data_rdata),
        .trc_valid    (trc_valid),
        .trc_ready    (trc_ready),
        .trc_pc       (trc_pc),
        .trc_addr     (trc_addr),
        .trc_data     (trc_data),
        .trc_count    (trc_count),
`ifdef DM_ADDR_CHECK_EN
        .addr_err     (addr_err),
`endif
        .trc_overflow (trc_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [3:0] be,
                               input logic [31:0] d, input logic [31:0] pc);
        m_data_addr   = a;
        m_data_byteen = be;
        m_data_wdata  = d;
        m_inst_addr   = pc;
    endtask

    task automatic idle_read(input logic [31:0] a);
        m_data_addr   = a;
        m_data_byteen = 4'b0000;
        m_data_wdata  = '0;
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc,
                              input logic [31:0] a, input logic [31:0] d);
        check_eq({tag, "_pc"},   trc_pc,   pc);
        check_eq({tag, "_addr"}, trc_addr, a);
        check_eq({tag, "_data"}, trc_data, d);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        trc_ready = 1'b0;
        drive_store(32'h0, 4'b0000, 32'h0, 32'h0);
        step();
        step();
        reset = 1'b0;

        // Reset state
        idle_read(32'h0000_0010);
        check_eq("rst_rdata", m_data_rdata, 32'h0);
        check_eq("rst_valid", {31'b0, trc_valid}, 32'h0);
        check_eq("rst_count", {28'b0, trc_count}, 32'h0);
        check_eq("rst_ovf",   {31'b0, trc_overflow}, 32'h0);
        check_head("rst_head", 32'h0, 32'h0, 32'h0);

        // Full-word store, then partial merges into the same word
        drive_store(32'h0000_0004, 4'b1111, 32'hDEAD_BEEF, 32'h0000_3000);
        #1;
        check_eq("st1_old", m_data_rdata, 32'h0);
        step();
        idle_read(32'h0000_0004);
        check_eq("st1_rd", m_data_rdata, 32'hDEAD_BEEF);
        check_eq("st1_valid", {31'b0, trc_valid}, 32'h1);
        check_eq("st1_count", {28'b0, trc_count}, 32'h1);
        check_head("st1_head", 32'h3000, 32'h4, 32'hDEAD_BEEF);

        drive_store(32'h0000_0006, 4'b1100, 32'h1234_0000, 32'h0000_3004);
        step();
        idle_read(32'h0000_0004);
        check_eq("st2_rd", m_data_rdata, 32'h1234_BEEF);

        drive_store(32'h0000_0005, 4'b0010, 32'h0000_AA00, 32'h0000_3008);
        step();
        idle_read(32'h0000_0004);
        check_eq("st3_rd", m_data_rdata, 32'h1234_AAEF);
        check_eq("st3_count", {28'b0, trc_count}, 32'h3);
`ifdef DM_ADDR_CHECK_EN
        idle_read(32'h0000_4004);
        check_eq("alias_rd", m_data_rdata, 32'h0);
`else
        idle_read(32'h0000_4004);
        check_eq("alias_rd", m_data_rdata, 32'h1234_AAEF);
`endif

        // Head must hold while not ready
        step();
        check_head("hold", 32'h3000, 32'h4, 32'hDEAD_BEEF);

        // Drain three records in store order
        trc_ready = 1'b1;
        #1;
        check_head("dr0", 32'h3000, 32'h4, 32'hDEAD_BEEF);
        step();
        check_head("dr1", 32'h3004, 32'h4, 32'h1234_BEEF);
        step();
        check_head("dr2", 32'h3008, 32'h4, 32'h1234_AAEF);
        step();
        trc_ready = 1'b0;
        #1;
        check_eq("dr_empty", {31'b0, trc_valid}, 32'h0);

        // Same-cycle read/write returns the old word
        drive_store(32'h0000_0008, 4'b1111, 32'h1111_1111, 32'h0000_4000);
        step();
        drive_store(32'h0000_0008, 4'b1111, 32'h5555_5555, 32'h0000_4004);
        #1;
        check_eq("rw_old", m_data_rdata, 32'h1111_1111);
        step();
        idle_read(32'h0000_0008);
        check_eq("rw_new", m_data_rdata, 32'h5555_5555);

        // Non-contiguous byte enables
        drive_store(32'h0000_0008, 4'b0101, 32'h00AB_00CD, 32'h0000_4008);
        step();
        idle_read(32'h0000_0008);
        check_eq("nc_rd", m_data_rdata, 32'h55AB_55CD);
        check_eq("nc_count", {28'b0, trc_count}, 32'h3);
        trc_ready = 1'b1;
        step();
        step();
        #1;
        check_head("nc_head", 32'h4008, 32'h8, 32'h55AB_55CD);
        step();
        trc_ready = 1'b0;
        #1;
        check_eq("nc_empty", {28'b0, trc_count}, 32'h0);

        // Fill FIFO exactly
        for (int k = 0; k < 8; k++) begin
            drive_store(32'h100 + 32'(k * 4), 4'b1111, 32'hA000_0000 + 32'(k), 32'h5000 + 32'(k * 4));
            step();
        end
        idle_read(32'h0);
        check_eq("full_count", {28'b0, trc_count}, 32'h8);
        check_eq("full_ovf", {31'b0, trc_overflow}, 32'h0);

        // Push and pop together while full
        trc_ready = 1'b1;
        drive_store(32'h120, 4'b1111, 32'hA000_0008, 32'h5020);
        step();
        trc_ready = 1'b0;
        idle_read(32'h0);
        check_eq("pp_count", {28'b0, trc_count}, 32'h8);
        check_eq("pp_ovf", {31'b0, trc_overflow}, 32'h0);

        // Push with no pop while full is dropped
        drive_store(32'h124, 4'b1111, 32'hA000_0009, 32'h5024);
        step();
        idle_read(32'h0);
        check_eq("ovf_count", {28'b0, trc_count}, 32'h8);
        check_eq("ovf_flag", {31'b0, trc_overflow}, 32'h1);

        // Every store reached the array, dropped one included
        for (int k = 0; k < 10; k++) begin
            idle_read(32'h100 + 32'(k * 4));
            check_eq($sformatf("arr%0d", k), m_data_rdata, 32'hA000_0000 + 32'(k));
        end

        // Partial drain in order: records 1..4
        trc_ready = 1'b1;
        #1;
        for (int k = 1; k < 5; k++) begin
            check_head($sformatf("ovdr%0d", k), 32'h5000 + 32'(k * 4),
                       32'h100 + 32'(k * 4), 32'hA000_0000 + 32'(k));
            step();
        end
        trc_ready = 1'b0;
        #1;
        check_eq("mid_count", {28'b0, trc_count}, 32'h4);
        check_eq("mid_ovf", {31'b0, trc_overflow}, 32'h1);

        // Reset mid-drain, with a store that reset must override
        reset = 1'b1;
        drive_store(32'h300, 4'b1111, 32'hFFFF_FFFF, 32'h7000);
        step();
        reset = 1'b0;
        idle_read(32'h300);
        check_eq("rr_store", m_data_rdata, 32'h0);
        check_eq("rr_count", {28'b0, trc_count}, 32'h0);
        check_eq("rr_valid", {31'b0, trc_valid}, 32'h0);
        check_eq("rr_ovf", {31'b0, trc_overflow}, 32'h0);
        check_head("rr_head", 32'h0, 32'h0, 32'h0);
        idle_read(32'h4);
        check_eq("rr_w4", m_data_rdata, 32'h0);
        idle_read(32'h8);
        check_eq("rr_w8", m_data_rdata, 32'h0);
        idle_read(32'h124);
        check_eq("rr_w124", m_data_rdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
